irs_block_readout_addr_v4: RTL

// Parametrised IRS read-address generator; successor to the v3 address block.

---
 rtl/irs_block_readout_addr_v4_pkg.sv | 27 ++
 rtl/irs_block_readout_addr_v4_if.sv | 30 +++
 rtl/irs_block_readout_addr_v4_syncedge.sv | 39 +++
 rtl/irs_block_readout_addr_v4.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/irs_block_readout_addr_v4_pkg.sv
// ============================================================================
// Module : irs_block_readout_addr_v4_pkg
// Brief  : Shared types and constants for the IRS read-address generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package irs_block_readout_addr_v4_pkg;

  localparam int DLY_BITS   = 8;
  localparam int RD_ADV_BIT = 0;
  localparam int RD_RST_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CHECK      = 3'd1,
    ST_ASSERT     = 3'd2,
    ST_RESETTING  = 3'd3,
    ST_RESET_WAIT = 3'd4,
    ST_COUNTING   = 3'd5,
    ST_COUNT_WAIT = 3'd6,
    ST_REACHED    = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/irs_block_readout_addr_v4_if.sv
// ============================================================================
// Module : irs_block_readout_addr_v4_if
// Brief  : Request/handshake bundle between readout sequencer and address block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface irs_block_readout_addr_v4_if #(
  parameter int ADDR_BITS = 9
);
  logic                 irs_mode_i;
  logic [ADDR_BITS-1:0] raddr_i;
  logic                 raddr_stb_i;
  logic                 raddr_reached_o;
  logic                 raddr_ack_o;
  logic                 busy_o;
  logic                 err_o;

  modport master (
    output irs_mode_i, raddr_i, raddr_stb_i,
    input  raddr_reached_o, raddr_ack_o, busy_o, err_o
  );

  modport slave (
    input  irs_mode_i, raddr_i, raddr_stb_i,
    output raddr_reached_o, raddr_ack_o, busy_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/irs_block_readout_addr_v4_syncedge.sv
// ============================================================================
// Module : irs_block_readout_addr_v4_syncedge
// Brief  : Rising-edge detector; LATENCY 0 is combinational, 1 is registered.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module irs_block_readout_addr_v4_syncedge #(
  parameter int LATENCY = 0
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  input  wire logic in_i,
  output logic      rise_o
);

  logic in_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) in_q <= 1'b0;
    else       in_q <= in_i;
  end

  generate
    if (LATENCY == 0) begin : g_lat0
      assign rise_o = in_i & ~in_q;
    end else begin : g_lat1
      logic rise_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rise_q <= 1'b0;
        else       rise_q <= in_i & ~in_q;
      end
      assign rise_o = rise_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/irs_block_readout_addr_v4.sv
// ============================================================================
// Module : irs_block_readout_addr_v4
// Brief  : IRS read-address generator: direct RD drive or IRS3 counter stepping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module irs_block_readout_addr_v4 #(
  parameter int ADDR_BITS    = 9,
  parameter int NBLOCKS      = 512,
  parameter int ASSERT_SETUP = 0,
  parameter int ADV_HIGH     = 0,
  parameter int ADV_LOW      = 0,
  parameter int RST_HIGH     = 0,
  parameter int RST_LOW      = 0
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_i,
  irs_block_readout_addr_v4_if.slave bus,
  input  wire logic                 ramp_done_i,
  output logic [ADDR_BITS-1:0]      irs_rd_o
);

  import irs_block_readout_addr_v4_pkg::*;

  localparam logic [ADDR_BITS:0]  NB_X      = (ADDR_BITS+1)'(NBLOCKS);
  localparam logic [DLY_BITS-1:0] LIM_SETUP = DLY_BITS'(ASSERT_SETUP);
  localparam logic [DLY_BITS-1:0] LIM_ADVH  = DLY_BITS'(ADV_HIGH);
  localparam logic [DLY_BITS-1:0] LIM_ADVL  = DLY_BITS'(ADV_LOW);
  localparam logic [DLY_BITS-1:0] LIM_RSTH  = DLY_BITS'(RST_HIGH);
  localparam logic [DLY_BITS-1:0] LIM_RSTL  = DLY_BITS'(RST_LOW);

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  tgt_q, tgt_d;
  logic [ADDR_BITS-1:0]  cur_q, cur_d;
  logic                  mode_q, mode_d;
  logic                  cnt_valid_q, cnt_valid_d;
  logic                  ramp_seen_q, ramp_seen_d;
  logic [DLY_BITS-1:0]   dly_q, dly_d;
  logic                  reached_q, reached_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [ADDR_BITS-1:0]  rd_q, rd_d;

  logic                  ramp_rise;
  logic [DLY_BITS-1:0]   dly_lim;
  logic                  dly_done;
  logic [ADDR_BITS:0]    tgt_x, cur_x, fwd;
  logic [ADDR_BITS-1:0]  cur_inc;
  logic                  addr_ok;

  irs_block_readout_addr_v4_syncedge #(.LATENCY(0)) u_ramp_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .in_i   (ramp_done_i),
    .rise_o (ramp_rise)
  );

  // Forward distance modulo NBLOCKS without assuming a power-of-two block count.
  assign tgt_x   = {1'b0, tgt_q};
  assign cur_x   = {1'b0, cur_q};
  assign fwd     = (tgt_x >= cur_x) ? (tgt_x - cur_x) : (tgt_x + NB_X - cur_x);
  assign cur_inc = (cur_x == NB_X - 1'b1) ? '0 : cur_q + 1'b1;
  assign addr_ok = ({1'b0, bus.raddr_i} < NB_X);

  always_comb begin
    dly_lim = '0;
    case (state_q)
      ST_ASSERT:     dly_lim = LIM_SETUP;
      ST_RESETTING:  dly_lim = LIM_RSTH;
      ST_RESET_WAIT: dly_lim = LIM_RSTL;
      ST_COUNTING:   dly_lim = LIM_ADVH;
      ST_COUNT_WAIT: dly_lim = LIM_ADVL;
      default:       dly_lim = '0;
    endcase
  end
  assign dly_done = (dly_q == dly_lim);

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    cur_d       = cur_q;
    mode_d      = mode_q;
    cnt_valid_d = cnt_valid_q;
    ramp_seen_d = (state_q == ST_IDLE) ? 1'b0 : (ramp_seen_q | ramp_rise);
    ack_d       = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.raddr_stb_i) begin
          if (addr_ok) begin
            tgt_d   = bus.raddr_i;
            mode_d  = bus.irs_mode_i;
            // Direct drive leaves the on-chip counter position unknown.
            if (!bus.irs_mode_i) cnt_valid_d = 1'b0;
            state_d = ST_CHECK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (cur_q == tgt_q && (!mode_q || cnt_valid_q)) state_d = ST_REACHED;
        else if (!mode_q)                               state_d = ST_ASSERT;
        else if (!cnt_valid_q || tgt_x < fwd)           state_d = ST_RESETTING;
        else                                            state_d = ST_COUNTING;
      end
      ST_ASSERT: begin
        cur_d = tgt_q;
        if (dly_done) state_d = ST_REACHED;
      end
      ST_RESETTING: begin
        if (dly_done) begin
          cur_d       = '0;
          cnt_valid_d = 1'b1;
          state_d     = ST_RESET_WAIT;
        end
      end
      ST_RESET_WAIT: begin
        if (dly_done) state_d = (tgt_q == '0) ? ST_REACHED : ST_COUNTING;
      end
      ST_COUNTING: begin
        if (dly_done) begin
          cur_d   = cur_inc;
          state_d = ST_COUNT_WAIT;
        end
      end
      ST_COUNT_WAIT: begin
        if (cur_q == tgt_q) state_d = ST_REACHED;
        else if (dly_done)  state_d = ST_COUNTING;
      end
      ST_REACHED: begin
        if (ramp_seen_q) begin
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    dly_d     = (state_d != state_q || state_q == ST_IDLE || state_q == ST_REACHED)
                ? '0 : dly_q + 1'b1;
    reached_d = (state_q == ST_REACHED);
    busy_d    = (state_q != ST_IDLE);

    rd_d = cur_d;
    if (mode_q) begin
      rd_d                  = '0;
      rd_d[ADDR_BITS-1:2]   = cur_d[ADDR_BITS-3:0];
      rd_d[RD_ADV_BIT]      = (state_q == ST_COUNTING);
      rd_d[RD_RST_BIT]      = (state_q == ST_RESETTING);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tgt_q       <= '0;
      cur_q       <= '0;
      mode_q      <= 1'b0;
      cnt_valid_q <= 1'b0;
      ramp_seen_q <= 1'b0;
      dly_q       <= '0;
      reached_q   <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      cur_q       <= cur_d;
      mode_q      <= mode_d;
      cnt_valid_q <= cnt_valid_d;
      ramp_seen_q <= ramp_seen_d;
      dly_q       <= dly_d;
      reached_q   <= reached_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
    end
  end

  assign bus.raddr_reached_o = reached_q;
  assign bus.raddr_ack_o     = ack_q;
  assign bus.busy_o          = busy_q;
  assign bus.err_o           = err_q;
  assign irs_rd_o            = rd_q;

endmodule

`default_nettype wire
